// File: rtl/phase_capture_deadlock_reporter.sv
// Confirms a persistent monitor block, latches info/timestamp, pulses irq and offers one report record.
// Outputs update one cycle after the qualifying edge; the record holds under report_ready backpressure until taken or cleared.
module phase_capture_deadlock_reporter #(
  parameter int AXIS_W         = 1,
  parameter int PERSIST_CYCLES = 16,
  parameter int TS_W           = 32,
  parameter int GLITCH_W       = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     block_in,
  input  logic [AXIS_W-1:0]        axis_block_info_in,
  input  logic                     clear,
  output logic                     deadlock,
  output logic                     irq,
  output logic [AXIS_W-1:0]        deadlock_axis_info,
  output logic [TS_W-1:0]          deadlock_time,
  output logic [GLITCH_W-1:0]      glitch_count,
  output logic                     report_valid,
  input  logic                     report_ready,
  output logic [AXIS_W+TS_W-1:0]   report_data
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_REPORT, S_LATCHED} state_t;

  localparam logic [16:0] LAST_CNT = 17'(PERSIST_CYCLES - 1);

  state_t              state, state_nxt;
  logic [16:0]         persist_cnt, cnt_nxt;
  logic [TS_W-1:0]     ts;
  logic                capture;
  logic                glitch;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      persist_cnt <= '0;
    end else begin
      state       <= state_nxt;
      persist_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = persist_cnt;
    capture   = 1'b0;
    glitch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (block_in) begin
          if (PERSIST_CYCLES == 1) begin
            state_nxt = S_REPORT;
            capture   = 1'b1;
          end else begin
            state_nxt = S_PENDING;
            cnt_nxt   = 17'd1;
          end
        end
      end
      S_PENDING: begin
        if (!block_in) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          glitch    = 1'b1;
        end else if (persist_cnt == LAST_CNT) begin
          state_nxt = S_REPORT;
          cnt_nxt   = '0;
          capture   = 1'b1;
        end else begin
          cnt_nxt = persist_cnt + 17'd1;
        end
      end
      S_REPORT: begin
        if (report_ready) state_nxt = S_LATCHED;
      end
      S_LATCHED: begin
        state_nxt = S_LATCHED;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Software clear overrides everything, including a detection on this edge.
    if (clear) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      capture   = 1'b0;
      glitch    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ts                 <= '0;
      irq                <= 1'b0;
      deadlock           <= 1'b0;
      deadlock_axis_info <= '0;
      deadlock_time      <= '0;
      glitch_count       <= '0;
    end else begin
      ts  <= ts + 1'b1;
      irq <= capture;
      if (clear) begin
        deadlock           <= 1'b0;
        deadlock_axis_info <= '0;
        deadlock_time      <= '0;
        glitch_count       <= '0;
      end else if (capture) begin
        deadlock           <= 1'b1;
        deadlock_axis_info <= axis_block_info_in;
        deadlock_time      <= ts;
      end else if (glitch && (glitch_count != {GLITCH_W{1'b1}})) begin
        glitch_count <= glitch_count + 1'b1;
      end
    end
  end

  assign report_valid = (state == S_REPORT);
  assign report_data  = {deadlock_axis_info, deadlock_time};

endmodule

// File: doc/phase_capture_deadlock_reporter.md
# phase_capture_deadlock_reporter

Downstream consumer of the phase-capture dataflow deadlock monitor's `block` and `axis_block_info` outputs. Qualifies the raw block indication by requiring it to persist for a configurable number of consecutive cycles. On a confirmed deadlock it latches a sticky flag, the AXI-Stream block vector and a timestamp, pulses an interrupt, and emits one report record over a valid/ready handshake. It also counts transient block episodes that clear before qualification, for debug.

## Interface
Parameters:
- `AXIS_W`, 1: width of the AXI-Stream block-info vector.
- `PERSIST_CYCLES`, 16: consecutive `block_in` cycles required to declare deadlock; legal range 1..2^16.
- `TS_W`, 32: width of the free-running timestamp counter.
- `GLITCH_W`, 16: width of the saturating transient-episode counter.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `block_in`  in  1: monitor deadlock indication.
- `axis_block_info_in`  in  AXIS_W: monitor per-channel AXIS block vector.
- `clear`  in  1: single-cycle software clear of the latched state.
- `deadlock`  out  1: sticky confirmed-deadlock flag.
- `irq`  out  1: one-cycle pulse on detection.
- `deadlock_axis_info`  out  AXIS_W: latched AXIS block vector.
- `deadlock_time`  out  TS_W: timestamp latched at detection.
- `glitch_count`  out  GLITCH_W: count of unqualified block episodes; saturates.
- `report_valid`  out  1: report record available.
- `report_ready`  in  1: report consumer ready.
- `report_data`  out  AXIS_W+TS_W: `{deadlock_axis_info, deadlock_time}`.

## Operation
- Timestamp counter `ts`:
  - Increments every cycle and wraps modulo 2^TS_W.
  - Reset sets it to 0.
  - `clear` does not affect it.
- FSM states:
  - **IDLE**
    - `block_in=1`: go to PENDING with `persist_cnt=1`.
    - If `PERSIST_CYCLES==1`, go directly to REPORT with the capture described below.
  - **PENDING**
    - `block_in=0`: go to IDLE, zero `persist_cnt`, increment `glitch_count` (saturating).
    - `block_in=1` and `persist_cnt==PERSIST_CYCLES-1`: go to REPORT.
    - `block_in=1` otherwise: increment `persist_cnt`.
  - **Capture on entry to REPORT** (on that clock edge):
    - `deadlock<=1`, `irq<=1` for one cycle.
    - `deadlock_axis_info<=axis_block_info_in`.
    - `deadlock_time<=ts` (the pre-increment value).
  - **REPORT**
    - `report_valid=1`, with `report_data` stable.
    - Transfer occurs on `report_valid & report_ready`; then go to LATCHED.
    - `block_in` is ignored.
  - **LATCHED**
    - `deadlock` held; `report_valid=0`; `block_in` ignored.
    - Remains here until `clear`.
- `clear`:
  - Priority over every FSM transition, including a same-cycle REPORT entry.
  - Next state is IDLE.
  - Zeroes `deadlock`, `deadlock_axis_info`, `deadlock_time`, `glitch_count`, `persist_cnt`; `report_valid` drops.
  - `block_in` sampled in the clear cycle is not counted.
  - A clear during REPORT abandons the record.
- `persist_cnt` is 17 bits wide and never exceeds PERSIST_CYCLES-1.

## Timing
- All outputs are registered.
- Reset values: `deadlock=0`, `irq=0`, `deadlock_axis_info=0`, `deadlock_time=0`, `glitch_count=0`, `report_valid=0`, `report_data=0`. Reset also sets FSM=IDLE and `ts=0`.
- Detection latency: with `block_in` high at edges k..k+N-1 (N=PERSIST_CYCLES), `deadlock`, `irq` and `report_valid` are high in the cycle after edge k+N-1. `deadlock_time` equals the `ts` value sampled at edge k+N-1.
- `irq` is high for exactly one cycle per detection.
- `report_valid` may be high together with `irq`.
- `report_valid` holds until accepted or cleared. `report_data` does not change while `report_valid=1`.
- If `report_ready` is already high when `report_valid` rises, the transfer completes in one cycle; `report_valid` is low the following cycle.
- `glitch_count` updates on the edge where `block_in` falls in PENDING; it saturates at 2^GLITCH_W-1.
- Reset mid-operation: all state returns to reset values on the next edge; any in-flight report is dropped.

## Test plan
- **Qualified deadlock:** N=16; from reset, hold `block_in=1` and `axis_block_info_in=1` for 16 cycles starting at ts=100, with `report_ready=1`. Expect `deadlock`/`irq` high after edge 115, `deadlock_time=115`, `report_data={1,115}`, one transfer, then LATCHED.
- **Glitches:** N=16; apply `block_in` high bursts of 3, 15 and 15 cycles separated by low cycles. Expect `glitch_count=3`, `deadlock=0`, `irq` never asserted.
- **Backpressure:** hold `report_ready=0` for 20 cycles after detection while `axis_block_info_in` and `block_in` toggle. Expect `report_valid` steady and `report_data` unchanged; transfer on the first `report_ready` cycle.
- **Clear:**
  - Assert `clear` during REPORT: `report_valid` low next cycle, all latches 0, FSM in IDLE.
  - Assert `clear` in the same cycle as the 16th `block_in`: no `irq`, and a later 16-cycle block re-detects.
- **Boundaries:**
  - N=1: a single `block_in` cycle gives `irq` on the next cycle.
  - GLITCH_W=2: 5 glitches leave `glitch_count=3`.
  - TS_W=4: detection at ts wraparound latches the wrapped value.
- **Reset:** assert `reset` in PENDING and in LATCHED. Every output is 0 the next cycle; `ts` restarts from 0.
